instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Multi-cycle fetch stage directly downstream of the program counter. It consumes the current PC and, on a start pulse from the control FSM, issues one word read to instruction memory over a req/ready + rvalid handshake. It latches the returned word into the instruction register and records the PC it was fetched from (old_pc) for branch/jump/AUIPC target computation. It flags misaligned PCs and memory timeouts, and pulses fetch_done so the control FSM can advance to decode.

Parameters:
TIMEOUT_CYCLES, 64, max cycles from entering REQ to mem_rvalid before bus_err; must be >= 2
RESET_INSTR, 32'h0000_0013, value of instr after reset (ADDI x0,x0,0 = NOP)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
fetch_start  input  1  control FSM request to fetch at pc; sampled only in IDLE
pc  input  32  current program counter from the PC stage
mem_req  output  1  read request valid to instruction memory
mem_addr  output  32  word read address; held stable while mem_req=1
mem_ready  input  1  memory accepts request in a cycle where mem_req=1
mem_rvalid  input  1  read data valid; honoured only in WAIT
mem_rdata  input  32  read data
instr  output  32  instruction register
old_pc  output  32  PC of the instruction currently in instr
fetch_done  output  1  one-cycle pulse: fetch attempt finished (success or error)
misaligned  output  1  sticky until next fetch_start: pc[1:0] != 0
bus_err  output  1  sticky until next fetch_start: timeout with no rvalid
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, instr=RESET_INSTR, old_pc=0, mem_addr=0, mem_req=0, fetch_done=0, misaligned=0, bus_err=0, timeout counter=0. Reset mid-fetch aborts the fetch and drops mem_req on the following cycle. Late rvalid after reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, fetch_start=1:
  - Capture addr_q<=pc, clear misaligned/bus_err, clear counter.
  - If pc[1:0]!=0: set misaligned, go to DONE. No memory request is issued.
  - Otherwise go to REQ.
  - fetch_start is ignored in any state other than IDLE.
- REQ: mem_req=1, mem_addr=addr_q. mem_ready=1 moves to WAIT. mem_rvalid is ignored in REQ.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1: instr<=mem_rdata, old_pc<=addr_q, go to DONE.
- Timeout:
  - The counter increments each cycle in REQ and WAIT.
  - If the counter equals TIMEOUT_CYCLES-1 and no acceptance/rvalid occurs this cycle: set bus_err, go to DONE. instr and old_pc stay unchanged.
  - rvalid in the expiry cycle wins; this is a normal completion.
  - Expiry in REQ also drops mem_req.
- DONE: fetch_done=1 for exactly one cycle, then IDLE. A fetch_start in DONE is ignored.
- Latency: fetch_start sampled at edge N, giving REQ in cycle N+1. With mem_ready in N+1 and rvalid in N+2, fetch_done is high in N+3 with instr valid. Misaligned: fetch_done in N+1.
- instr/old_pc change only on successful rvalid capture and hold otherwise.
- Counter width: $clog2(TIMEOUT_CYCLES+1); no wrap possible.
- mem_addr is driven from addr_q, so it stays stable even if pc changes during a fetch.

Test Plan:
- Reset then idle: instr=32'h00000013, old_pc=0, mem_req=0, busy=0 for 5 cycles.
- Zero-wait fetch: pc=0x100, fetch_start, mem_ready immediate, rvalid next cycle with 0x00500093 -> mem_addr=0x100, fetch_done 3 cycles after start, instr=0x00500093, old_pc=0x100.
- Stalls: mem_ready delayed 4 cycles, rvalid 3 more; pc changed to 0x200 mid-fetch -> mem_addr held 0x100 throughout, instr captured, old_pc=0x100.
- Misaligned: pc=0x102, fetch_start -> mem_req never high, misaligned=1, fetch_done next cycle, instr unchanged. Next aligned fetch clears misaligned.
- Timeout, TIMEOUT_CYCLES=8, no rvalid -> bus_err=1 and fetch_done exactly 8 cycles after REQ entry, instr unchanged. Repeat with rvalid in the expiry cycle -> bus_err=0, instr captured.
- rst asserted in WAIT, then rvalid arrives -> state IDLE, instr=NOP, rvalid ignored. fetch_start during busy -> no second request.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory read handshake bundle
//
// Purpose: groups the fetch unit's request/response signals to instruction memory.
// Signals:
//   mem_req    fetch unit -> memory : read request valid
//   mem_addr   fetch unit -> memory : word read address, stable while mem_req=1
//   mem_ready  memory -> fetch unit : request accepted in a cycle with mem_req=1
//   mem_rvalid memory -> fetch unit : read data valid
//   mem_rdata  memory -> fetch unit : read data
// Modports: master (fetch unit side), slave (memory side).
interface instruction_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - multi-cycle instruction fetch stage
//
// Purpose: on fetch_start (sampled in IDLE) issues one word read at pc to
// instruction memory, captures the returned word into instr and its address
// into old_pc, flags misaligned PCs and memory timeouts, and pulses fetch_done.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   fetch_start   request from control FSM, honoured only in IDLE
//   pc            current program counter
//   mem           instruction memory handshake (master side)
//   instr         instruction register
//   old_pc        address the word in instr was fetched from
//   fetch_done    one-cycle pulse when a fetch attempt finishes
//   misaligned    sticky until next fetch_start: pc[1:0] != 0
//   bus_err       sticky until next fetch_start: memory timeout
//   busy          high in every state except IDLE
module instruction_fetch_unit #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_start,
  input  logic [31:0]                     pc,
  instruction_fetch_unit_if.master        mem,
  output logic [31:0]                     instr,
  output logic [31:0]                     old_pc,
  output logic                            fetch_done,
  output logic                            misaligned,
  output logic                            bus_err,
  output logic                            busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   old_pc_q, old_pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          misaligned_q, misaligned_d;
  logic          bus_err_q, bus_err_d;
  logic          expired;
  logic [CW-1:0] cnt_inc;

  // ">=" rather than "==": a request accepted in the very last REQ cycle enters
  // WAIT with the counter already past the limit, and must still time out.
  assign expired = (cnt_q >= CNT_LAST);
  // Saturate so the counter can never wrap back into a non-expired value.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    old_pc_d     = old_pc_q;
    cnt_d        = cnt_q;
    misaligned_d = misaligned_q;
    bus_err_d    = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          addr_d       = pc;
          misaligned_d = 1'b0;
          bus_err_d    = 1'b0;
          cnt_d        = '0;
          if (pc[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        // Acceptance beats expiry; rvalid is not looked at here.
        if (mem.mem_ready) begin
          state_d = S_WAIT;
        end else if (expired) begin
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // rvalid in the expiry cycle is a normal completion.
        if (mem.mem_rvalid) begin
          instr_d  = mem.mem_rdata;
          old_pc_d = addr_q;
          state_d  = S_DONE;
        end else if (expired) begin
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      instr_q      <= RESET_INSTR;
      old_pc_q     <= '0;
      cnt_q        <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      old_pc_q     <= old_pc_d;
      cnt_q        <= cnt_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // mem_addr comes from the captured address so pc may move during a fetch.
  assign mem.mem_req  = (state_q == S_REQ);
  assign mem.mem_addr = addr_q;
  assign instr        = instr_q;
  assign old_pc       = old_pc_q;
  assign fetch_done   = (state_q == S_DONE);
  assign misaligned   = misaligned_q;
  assign bus_err      = bus_err_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam int          T   = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        fetch_start;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] old_pc;
  logic        fetch_done;
  logic        misaligned;
  logic        bus_err;
  logic        busy;

  instruction_fetch_unit_if mif ();

  instruction_fetch_unit #(
    .TIMEOUT_CYCLES (T),
    .RESET_INSTR    (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc          (pc),
    .mem         (mif),
    .instr       (instr),
    .old_pc      (old_pc),
    .fetch_done  (fetch_done),
    .misaligned  (misaligned),
    .bus_err     (bus_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference architectural state
  logic [31:0] exp_instr;
  logic [31:0] exp_old_pc;
  // Expected timeline of the current fetch (cycle index 0 = first cycle after start edge)
  int e_done;
  int e_req_cnt;
  bit e_err;
  bit e_mis;
  // Observations of the current fetch
  int obs_done;
  int obs_req_cnt;
  int obs_addr_bad;
  bit obs_idle_after;

  // Timeline model: request window, completion cycle and outcome from the handshake delays.
  task automatic model_fetch(input logic [31:0] p, input int d1, input int d2,
                             input bit has_rv, input logic [31:0] data);
    int r;
    r     = d1 + 1 + d2;
    e_err = 0;
    e_mis = (p[1:0] != 2'b00);
    if (e_mis) begin
      e_done    = 0;
      e_req_cnt = 0;
    end else if (d1 > T - 1) begin
      e_done    = T;
      e_req_cnt = T;
      e_err     = 1;
    end else begin
      e_req_cnt = d1 + 1;
      if (has_rv && r <= T - 1) begin
        e_done     = r + 1;
        exp_instr  = data;
        exp_old_pc = p;
      end else begin
        e_done = T;
        e_err  = 1;
      end
    end
  endtask

  // Drives one fetch and the memory side; records what the DUT did.
  task automatic run_fetch(input logic [31:0] p, input int d1, input int d2,
                           input bit has_rv, input bit noise, input logic [31:0] data);
    int r;
    bit fin;
    r              = d1 + 1 + d2;
    obs_done       = -1;
    obs_req_cnt    = 0;
    obs_addr_bad   = 0;
    obs_idle_after = 0;
    fin            = 0;
    pc             = p;
    fetch_start    = 1'b1;
    for (int idx = 0; idx <= T + 4 && !fin; idx++) begin
      @(posedge clk);
      #1;
      if (obs_done >= 0) begin
        obs_idle_after = !busy && !mif.mem_req && !fetch_done;
        fin = 1;
      end else begin
        if (mif.mem_req) begin
          obs_req_cnt++;
          if (mif.mem_addr !== p) obs_addr_bad++;
        end
        if (fetch_done) obs_done = idx;
      end
      mif.mem_ready  = (idx == d1);
      mif.mem_rvalid = (has_rv && idx == r) || (noise && idx <= d1 && ($urandom % 2 == 1));
      mif.mem_rdata  = (idx == r) ? data : $urandom;
      fetch_start    = noise && !fin && ($urandom % 2 == 1);
      if (noise) pc = $urandom;
    end
    fetch_start    = 1'b0;
    mif.mem_ready  = 1'b0;
    mif.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    exp_instr  = NOP;
    exp_old_pc = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++; if (instr !== NOP) begin miscompares++; $display("FAIL rst_instr got %h exp %h", instr, NOP); end
      vectors++; if (old_pc !== 32'h0) begin miscompares++; $display("FAIL rst_old_pc got %h exp 0", old_pc); end
      vectors++; if (mif.mem_req !== 1'b0 || busy !== 1'b0 || fetch_done !== 1'b0) begin
        miscompares++; $display("FAIL rst_idle req=%b busy=%b done=%b exp 0 0 0", mif.mem_req, busy, fetch_done); end
    end
    vectors++; if (misaligned !== 1'b0 || bus_err !== 1'b0 || mif.mem_addr !== 32'h0) begin
      miscompares++; $display("FAIL rst_flags mis=%b err=%b addr=%h exp 0 0 0", misaligned, bus_err, mif.mem_addr); end
  endtask

  task automatic test_zero_wait;
    model_fetch(32'h100, 0, 0, 1, 32'h0050_0093);
    run_fetch(32'h100, 0, 0, 1, 0, 32'h0050_0093);
    vectors++; if (obs_done !== 2) begin miscompares++; $display("FAIL zw_latency got %0d exp 2", obs_done); end
    vectors++; if (obs_req_cnt !== 1 || obs_addr_bad !== 0) begin miscompares++; $display("FAIL zw_req cnt=%0d bad=%0d exp 1 0", obs_req_cnt, obs_addr_bad); end
    vectors++; if (instr !== 32'h0050_0093) begin miscompares++; $display("FAIL zw_instr got %h exp 00500093", instr); end
    vectors++; if (old_pc !== 32'h100) begin miscompares++; $display("FAIL zw_old_pc got %h exp 100", old_pc); end
    vectors++; if (!obs_idle_after) begin miscompares++; $display("FAIL zw_idle got 0 exp 1"); end
  endtask

  task automatic test_stalls;
    model_fetch(32'h100, 4, 2, 1, 32'h1234_5678);
    run_fetch(32'h100, 4, 2, 1, 1, 32'h1234_5678);
    vectors++; if (obs_done !== e_done) begin miscompares++; $display("FAIL st_done got %0d exp %0d", obs_done, e_done); end
    vectors++; if (obs_req_cnt !== e_req_cnt || obs_addr_bad !== 0) begin
      miscompares++; $display("FAIL st_req cnt=%0d bad=%0d exp %0d 0", obs_req_cnt, obs_addr_bad, e_req_cnt); end
    vectors++; if (instr !== exp_instr || old_pc !== exp_old_pc) begin
      miscompares++; $display("FAIL st_capture got %h/%h exp %h/%h", instr, old_pc, exp_instr, exp_old_pc); end
  endtask

  task automatic test_misaligned;
    model_fetch(32'h102, 0, 0, 1, 32'hdead_beef);
    run_fetch(32'h102, 0, 0, 1, 0, 32'hdead_beef);
    vectors++; if (obs_done !== 0 || obs_req_cnt !== 0) begin
      miscompares++; $display("FAIL mis_timing done=%0d req=%0d exp 0 0", obs_done, obs_req_cnt); end
    vectors++; if (misaligned !== 1'b1 || bus_err !== 1'b0) begin
      miscompares++; $display("FAIL mis_flags mis=%b err=%b exp 1 0", misaligned, bus_err); end
    vectors++; if (instr !== exp_instr) begin miscompares++; $display("FAIL mis_instr got %h exp %h", instr, exp_instr); end
    model_fetch(32'h204, 1, 0, 1, 32'h0000_0033);
    run_fetch(32'h204, 1, 0, 1, 0, 32'h0000_0033);
    vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL mis_clear got %b exp 0", misaligned); end
  endtask

  task automatic test_timeout;
    model_fetch(32'h400, 0, 0, 0, 32'h0);
    run_fetch(32'h400, 0, 0, 0, 0, 32'h0);
    vectors++; if (obs_done !== T) begin miscompares++; $display("FAIL to_done got %0d exp %0d", obs_done, T); end
    vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL to_err got %b exp 1", bus_err); end
    vectors++; if (instr !== exp_instr || old_pc !== exp_old_pc) begin
      miscompares++; $display("FAIL to_hold got %h/%h exp %h/%h", instr, old_pc, exp_instr, exp_old_pc); end
    model_fetch(32'h404, T + 3, 0, 0, 32'h0);
    run_fetch(32'h404, T + 3, 0, 0, 0, 32'h0);
    vectors++; if (obs_done !== T || obs_req_cnt !== T || bus_err !== 1'b1) begin
      miscompares++; $display("FAIL to_req done=%0d req=%0d err=%b exp %0d %0d 1", obs_done, obs_req_cnt, bus_err, T, T); end
    model_fetch(32'h408, 0, T - 2, 1, 32'hcafe_f00d);
    run_fetch(32'h408, 0, T - 2, 1, 0, 32'hcafe_f00d);
    vectors++; if (obs_done !== T || bus_err !== 1'b0) begin
      miscompares++; $display("FAIL to_edge done=%0d err=%b exp %0d 0", obs_done, bus_err, T); end
    vectors++; if (instr !== 32'hcafe_f00d || old_pc !== 32'h408) begin
      miscompares++; $display("FAIL to_edge_cap got %h/%h exp cafef00d/00000408", instr, old_pc); end
  endtask

  task automatic test_reset_mid_fetch;
    pc = 32'h300;
    fetch_start = 1'b1;
    @(posedge clk); #1;
    fetch_start   = 1'b0;
    mif.mem_ready = 1'b1;
    @(posedge clk); #1;
    mif.mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    exp_instr  = NOP;
    exp_old_pc = '0;
    vectors++; if (busy !== 1'b0 || mif.mem_req !== 1'b0 || instr !== NOP || old_pc !== 32'h0) begin
      miscompares++; $display("FAIL rw_state busy=%b req=%b instr=%h old=%h exp 0 0 %h 0", busy, mif.mem_req, instr, old_pc, NOP); end
    mif.mem_rvalid = 1'b1;
    mif.mem_rdata  = 32'hdead_beef;
    @(posedge clk); #1;
    mif.mem_rvalid = 1'b0;
    vectors++; if (instr !== NOP || fetch_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rw_late_rvalid instr=%h done=%b busy=%b exp %h 0 0", instr, fetch_done, busy, NOP); end
    // reset while in REQ drops the request on the following cycle
    pc = 32'h310;
    fetch_start = 1'b1;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (mif.mem_req !== 1'b0 || mif.mem_addr !== 32'h0) begin
      miscompares++; $display("FAIL rr_drop req=%b addr=%h exp 0 0", mif.mem_req, mif.mem_addr); end
  endtask

  task automatic test_busy_start_ignored;
    int extra;
    model_fetch(32'h500, 2, 1, 1, 32'h00a0_0113);
    run_fetch(32'h500, 2, 1, 1, 1, 32'h00a0_0113);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mif.mem_req || fetch_done || busy) extra++;
    end
    vectors++; if (obs_req_cnt !== 3 || obs_done !== e_done) begin
      miscompares++; $display("FAIL bs_req cnt=%0d done=%0d exp 3 %0d", obs_req_cnt, obs_done, e_done); end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL bs_second got %0d active cycles exp 0", extra); end
    vectors++; if (instr !== exp_instr) begin miscompares++; $display("FAIL bs_instr got %h exp %h", instr, exp_instr); end
  endtask

  task automatic test_random;
    logic [31:0] p;
    logic [31:0] data;
    int d1, d2;
    bit has_rv, noise;
    for (int n = 0; n < 30; n++) begin
      p      = $urandom;
      if ($urandom % 6 != 0) p[1:0] = 2'b00;
      d1     = ($urandom % 5 == 0) ? T + 3 : $urandom_range(0, T - 2);
      d2     = $urandom_range(0, T);
      has_rv = ($urandom % 4 != 0);
      noise  = ($urandom % 2 == 1);
      data   = $urandom;
      model_fetch(p, d1, d2, has_rv, data);
      run_fetch(p, d1, d2, has_rv, noise, data);
      vectors++; if (obs_done !== e_done) begin miscompares++; $display("FAIL rnd%0d_done got %0d exp %0d", n, obs_done, e_done); end
      vectors++; if (obs_req_cnt !== e_req_cnt || obs_addr_bad !== 0) begin
        miscompares++; $display("FAIL rnd%0d_req cnt=%0d bad=%0d exp %0d 0", n, obs_req_cnt, obs_addr_bad, e_req_cnt); end
      vectors++; if (misaligned !== e_mis || bus_err !== e_err) begin
        miscompares++; $display("FAIL rnd%0d_flags mis=%b err=%b exp %b %b", n, misaligned, bus_err, e_mis, e_err); end
      vectors++; if (instr !== exp_instr || old_pc !== exp_old_pc) begin
        miscompares++; $display("FAIL rnd%0d_regs got %h/%h exp %h/%h", n, instr, old_pc, exp_instr, exp_old_pc); end
      vectors++; if (!obs_idle_after) begin miscompares++; $display("FAIL rnd%0d_idle got 0 exp 1", n); end
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    fetch_start    = 1'b0;
    pc             = '0;
    mif.mem_ready  = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = '0;
    test_reset();
    test_zero_wait();
    test_stalls();
    test_misaligned();
    test_timeout();
    test_reset_mid_fetch();
    test_busy_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
